// File: rtl/detector_sequencer.sv
// Serialises one pattern word into an external detector, MSB first, and
// collects the detector's one-cycle-late match responses into a hit mask,
// a hit count and a snapshot of the detector state bits.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; start is level-sensitive here
// ST_SHIFT | driving word bit bit_idx on serial_out, bit_idx counts down
// ST_DRAIN | line idle, collecting the response to the last driven bit
// ST_DONE  | one-cycle completion pulse, results held
module detector_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] word,
   input  logic [3:0]       length,
   input  logic             boolean,
   input  logic [3:0]       state,
   output logic             serial_out,
   output logic             busy,
   output logic             done,
   output logic [3:0]       hit_count,
   output logic [WIDTH-1:0] hit_mask,
   output logic [3:0]       last_state
);

   localparam int         IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [3:0] WLEN = 4'(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DRAIN,
      ST_DONE
   } st_t;

   st_t              cur_st;
   st_t              nxt_st;
   logic             accept;
   logic [3:0]       eff_len;
   logic [WIDTH-1:0] word_q;
   logic [IW-1:0]    bit_idx;
   logic [IW-1:0]    prev_idx;
   logic             prev_vld;

   // A zero or oversized length falls back to the full word width.
   assign eff_len = ((length == 4'd0) || (length > WLEN)) ? WLEN : length;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur_st <= ST_IDLE;
      end else begin
         cur_st <= nxt_st;
      end
   end

   // Next-state decode; outputs depend only on registers, never on inputs.
   always_comb begin
      nxt_st     = cur_st;
      accept     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      serial_out = 1'b0;
      case (cur_st)
         ST_IDLE: begin
            if (start) begin
               accept = 1'b1;
               nxt_st = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            busy       = 1'b1;
            serial_out = word_q[bit_idx];
            if (bit_idx == '0) begin
               nxt_st = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            busy   = 1'b1;
            nxt_st = ST_DONE;
         end
         ST_DONE: begin
            done   = 1'b1;
            nxt_st = ST_IDLE;
         end
         default: nxt_st = ST_IDLE;
      endcase
   end

   // Pattern latch, bit down-counter and response collection. The detector
   // answers one cycle late, so each sample is credited to the bit index
   // that was on the line during the previous cycle (prev_idx/prev_vld).
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         word_q     <= '0;
         bit_idx    <= '0;
         prev_idx   <= '0;
         prev_vld   <= 1'b0;
         hit_count  <= 4'd0;
         hit_mask   <= '0;
         last_state <= 4'd0;
      end else begin
         prev_vld <= (cur_st == ST_SHIFT);
         prev_idx <= bit_idx;
         if (accept) begin
            word_q    <= word;
            bit_idx   <= IW'(eff_len - 4'd1);
            hit_count <= 4'd0;
            hit_mask  <= '0;
         end else begin
            if ((cur_st == ST_SHIFT) && (bit_idx != '0)) begin
               bit_idx <= bit_idx - 1'b1;
            end
            if (prev_vld && boolean) begin
               hit_mask[prev_idx] <= 1'b1;
               hit_count          <= hit_count + 4'd1;
            end
         end
         if (cur_st == ST_DRAIN) begin
            last_state <= state;
         end
      end
   end

endmodule

// File: tb/tb_detector_sequencer.sv
// Directed bench for detector_sequencer with a stub detector that echoes
// serial_out one cycle later and keeps the last four line bits as its state.
module tb_detector_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] word  = 8'h00;
   logic [3:0] length = 4'd0;
   logic       boolean = 1'b0;
   logic [3:0] state = 4'd0;
   logic       serial_out;
   logic       busy;
   logic       done;
   logic [3:0] hit_count;
   logic [7:0] hit_mask;
   logic [3:0] last_state;

   int compared   = 0;
   int mismatched = 0;

   detector_sequencer #(.WIDTH(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .word       (word),
      .length     (length),
      .boolean    (boolean),
      .state      (state),
      .serial_out (serial_out),
      .busy       (busy),
      .done       (done),
      .hit_count  (hit_count),
      .hit_mask   (hit_mask),
      .last_state (last_state)
   );

   always #5 clock = ~clock;

   // Stub detector.
   always @(posedge clock) begin
      boolean <= serial_out;
      state   <= {state[2:0], serial_out};
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full run from IDLE; optional ignored start pulses in a SHIFT cycle
   // and in DONE. Expected results are hand-computed by the caller.
   task automatic run(input string nm, input logic [7:0] w, input logic [3:0] len,
                      input int eff, input logic [7:0] emask, input logic [3:0] ecnt,
                      input logic [3:0] elast, input int pulse_shift, input bit pulse_done);
      word   = w;
      length = len;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      for (int i = 0; i < eff; i++) begin
         chk({nm, " shift busy"}, 32'(busy), 32'd1);
         chk({nm, " shift done"}, 32'(done), 32'd0);
         chk({nm, " serial bit"}, 32'(serial_out), 32'(w[eff-1-i]));
         if (i == pulse_shift) begin
            start = 1'b1;
            word  = ~w;
            length = 4'd1;
         end
         tick();
         start = 1'b0;
      end
      chk({nm, " drain busy"}, 32'(busy), 32'd1);
      chk({nm, " drain serial"}, 32'(serial_out), 32'd0);
      chk({nm, " drain done"}, 32'(done), 32'd0);
      tick();
      chk({nm, " done pulse"}, 32'(done), 32'd1);
      chk({nm, " done busy"}, 32'(busy), 32'd0);
      chk({nm, " done serial"}, 32'(serial_out), 32'd0);
      if (pulse_done) start = 1'b1;
      tick();
      start = 1'b0;
      chk({nm, " done fall"}, 32'(done), 32'd0);
      chk({nm, " hit_mask"}, 32'(hit_mask), 32'(emask));
      chk({nm, " hit_count"}, 32'(hit_count), 32'(ecnt));
      chk({nm, " last_state"}, 32'(last_state), 32'(elast));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk({nm, " idle busy"}, 32'(busy), 32'd0);
         chk({nm, " idle done"}, 32'(done), 32'd0);
         chk({nm, " hold mask"}, 32'(hit_mask), 32'(emask));
      end
   endtask

   initial begin
      int last_done;
      int n_done;

      tick();
      tick();
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset serial", 32'(serial_out), 32'd0);
      chk("reset hit_count", 32'(hit_count), 32'd0);
      chk("reset hit_mask", 32'(hit_mask), 32'd0);
      chk("reset last_state", 32'(last_state), 32'd0);
      reset = 1'b0;

      // Accepted on the first edge after reset release.
      run("b2_len8", 8'hB2, 4'd8, 8, 8'hB2, 4'd4, 4'b0010, -1, 1'b0);
      run("ff_len3", 8'hFF, 4'd3, 3, 8'h07, 4'd3, 4'b0111, -1, 1'b0);
      run("len0",    8'h01, 4'd0, 8, 8'h01, 4'd1, 4'b0001, -1, 1'b0);
      run("len_over", 8'h81, 4'd12, 8, 8'h81, 4'd2, 4'b0001, -1, 1'b0);
      run("ignore",  8'hA5, 4'd4, 4, 8'h05, 4'd2, 4'b0101, 1, 1'b1);

      // Reset in SHIFT cycle 3 aborts the run.
      word   = 8'hB2;
      length = 4'd8;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      tick();
      tick();
      tick();
      chk("pre-abort busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort serial", 32'(serial_out), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort hit_count", 32'(hit_count), 32'd0);
      chk("abort hit_mask", 32'(hit_mask), 32'd0);
      chk("abort last_state", 32'(last_state), 32'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("post-abort no done", 32'(done), 32'd0);
         chk("post-abort idle", 32'(busy), 32'd0);
      end
      run("after_abort", 8'h3C, 4'd8, 8, 8'h3C, 4'd4, 4'b1100, -1, 1'b0);

      // Start held high: back-to-back runs of length 2, one every 5 cycles.
      word      = 8'hFE;
      length    = 4'd2;
      start     = 1'b1;
      last_done = -1;
      n_done    = 0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (c % 5 == 1) begin
            chk("held shift0 busy", 32'(busy), 32'd1);
            chk("held cleared count", 32'(hit_count), 32'd0);
            chk("held cleared mask", 32'(hit_mask), 32'd0);
         end
         if (done) begin
            n_done++;
            chk("held done phase", 32'(c % 5), 32'd4);
            if (last_done >= 0) chk("held done spacing", 32'(c - last_done), 32'd5);
            chk("held hit_count", 32'(hit_count), 32'd1);
            chk("held hit_mask", 32'(hit_mask), 32'h02);
            chk("held last_state", 32'(last_state), 32'b0010);
            last_done = c;
         end
      end
      start = 1'b0;
      chk("held done total", 32'(n_done), 32'd6);
      for (int i = 0; i < 8; i++) tick();
      chk("held end idle", 32'(busy), 32'd0);
      chk("held end done", 32'(done), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
